// File: rtl/gpu_pkg.sv
// Shared GPU command definitions: opcodes, queue FSM states and packet length lookup.
// Used by gpu_cmd_queue and the GPU core.
package gpu_pkg;

  localparam logic [15:0] GPU_OP_SWAP  = 16'd0;
  localparam logic [15:0] GPU_OP_CMAP  = 16'd1;
  localparam logic [15:0] GPU_OP_PIXEL = 16'd2;
  localparam logic [15:0] GPU_OP_RECT  = 16'd3;

  typedef enum logic {
    Q_IDLE,
    Q_ARGS
  } q_state_e;

  // Packet length in words, header included.
  function automatic logic [2:0] gpu_op_len(input logic [15:0] op);
    logic [2:0] len;
    case (op)
      GPU_OP_SWAP:  len = 3'd1;
      GPU_OP_CMAP:  len = 3'd5;
      GPU_OP_PIXEL: len = 3'd2;
      GPU_OP_RECT:  len = 3'd3;
      default:      len = 3'd1;
    endcase
    return len;
  endfunction

  function automatic logic gpu_op_known(input logic [15:0] op);
    return op <= GPU_OP_RECT;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Single-clock show-ahead FIFO; rdata is the head word (0 when empty).
// Ports: clk, rst, push/wdata, pop/rdata, full, empty, level.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = 1;

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wptr;
  logic [AW:0]  rptr;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) &&
                 (wptr[AW-1:0] == rptr[AW-1:0]);
  assign level = wptr - rptr;
  assign rdata = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push && !full)
        wptr <= wptr + ONE;
      if (pop && !empty)
        rptr <= rptr + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/gpu_cmd_queue.sv
// Packet-aware CPU->GPU command buffer: a header is released only once its whole packet is buffered.
// Ports: clk, rst, wr_valid/wr_data/wr_ready, dv/dout/gpu_ready, level, bad_op; GPU_CMDQ_STATS_EN adds cmd_count, stall_count.
module gpu_cmd_queue
  import gpu_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_valid,
  input  logic [31:0]              wr_data,
  output logic                     wr_ready,
  output logic                     dv,
  output logic [31:0]              dout,
  input  logic                     gpu_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     bad_op
`ifdef GPU_CMDQ_STATS_EN
  ,
  output logic [31:0]              cmd_count,
  output logic [31:0]              stall_count
`endif
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] ONE = 1;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          issue;
  logic          pkt_done;
  logic [2:0]    hdr_len;
  logic [2:0]    head_len;
  logic [2:0]    wpos;
  logic [2:0]    wlen;
  logic [2:0]    rem;
  logic [LW-1:0] pkts;
  q_state_e      state;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (32)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (wr_data),
    .pop   (pop),
    .rdata (dout),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  assign wr_ready = !full;
  assign push     = wr_valid && !full;
  assign hdr_len  = gpu_op_len(wr_data[15:0]);
  assign head_len = gpu_op_len(dout[15:0]);

  // A packet completes on its header when it is a single word.
  assign pkt_done = push &&
                    ((wpos == 3'd0) ? (hdr_len == 3'd1)
                                    : (wpos == wlen - 3'd1));

  assign issue = (state == Q_IDLE) && (pkts != '0) && gpu_ready;
  assign pop   = issue || (state == Q_ARGS);
  assign dv    = issue;

  always_ff @(posedge clk) begin
    if (rst) begin
      wpos   <= 3'd0;
      wlen   <= 3'd1;
      bad_op <= 1'b0;
    end else if (push) begin
      if (wpos == 3'd0) begin
        wlen <= hdr_len;
        if (!gpu_op_known(wr_data[15:0]))
          bad_op <= 1'b1;
      end
      wpos <= pkt_done ? 3'd0 : wpos + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      pkts <= '0;
    else if (pkt_done && !issue)
      pkts <= pkts + ONE;
    else if (!pkt_done && issue)
      pkts <= pkts - ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= Q_IDLE;
      rem   <= 3'd0;
    end else begin
      unique case (state)
        Q_IDLE: begin
          if (issue) begin
            rem   <= head_len - 3'd1;
            state <= (head_len != 3'd1) ? Q_ARGS : Q_IDLE;
          end
        end
        Q_ARGS: begin
          rem <= rem - 3'd1;
          if (rem == 3'd1)
            state <= Q_IDLE;
        end
      endcase
    end
  end

`ifdef GPU_CMDQ_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_count   <= 32'd0;
      stall_count <= 32'd0;
    end else begin
      if (issue && cmd_count != 32'hFFFF_FFFF)
        cmd_count <= cmd_count + 32'd1;
      if (pkts != '0 && !gpu_ready)
        stall_count <= stall_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gpu_cmd_queue.sv
// Randomized and directed bench for gpu_cmd_queue against a word-queue reference model.
// Model parses the buffered word list by packet lengths to decide header release.
module tb_gpu_cmd_queue;

  localparam int DEPTH = 16;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [31:0]   wr_data;
  logic          wr_ready;
  logic          dv;
  logic [31:0]   dout;
  logic          gpu_ready;
  logic [LW-1:0] level;
  logic          bad_op;
`ifdef GPU_CMDQ_STATS_EN
  logic [31:0]   cmd_count;
  logic [31:0]   stall_count;
`endif

  gpu_cmd_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .wr_valid    (wr_valid),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .dv          (dv),
    .dout        (dout),
    .gpu_ready   (gpu_ready),
    .level       (level),
    .bad_op      (bad_op)
`ifdef GPU_CMDQ_STATS_EN
    ,
    .cmd_count   (cmd_count),
    .stall_count (stall_count)
`endif
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference model: buffered words, args still owed, write-side words left.
  logic [31:0] q[$];
  int          margs;
  int          wleft;
  bit          mbad;
  int          nhdr;
  int          nstall;
  logic [31:0] gen[$];

  function automatic int oplen(input logic [31:0] w);
    case (w[15:0])
      16'd0:   return 1;
      16'd1:   return 5;
      16'd2:   return 2;
      16'd3:   return 3;
      default: return 1;
    endcase
  endfunction

  // Number of complete packets waiting behind any in-flight arguments.
  function automatic int ready_pkts();
    int i = margs;
    int n = 0;
    while (i < q.size()) begin
      int l = oplen(q[i]);
      if (i + l > q.size())
        break;
      n++;
      i += l;
    end
    return n;
  endfunction

  function automatic void model_clear();
    q.delete();
    margs = 0;
    wleft = 0;
    mbad  = 0;
  endfunction

  task automatic cycle(input bit v, input logic [31:0] d, input bit g);
    bit          iss;
    bit          acc;
    bit          pop;
    logic [31:0] h;
    @(negedge clk);
    wr_valid  = v;
    wr_data   = d;
    gpu_ready = g;
    #1;
    h   = (q.size() != 0) ? q[0] : 32'd0;
    iss = (margs == 0) && (ready_pkts() > 0) && g;
    acc = v && (q.size() < DEPTH);
    pop = iss || (margs > 0);
    chk("dv", {31'd0, dv}, {31'd0, iss});
    chk("dout", dout, h);
    chk("level", 32'(level), 32'(q.size()));
    chk("wr_ready", {31'd0, wr_ready}, {31'd0, q.size() < DEPTH});
    chk("bad_op", {31'd0, bad_op}, {31'd0, mbad});
    if (ready_pkts() > 0 && !g && margs == 0)
      nstall++;
    else if (margs > 0 && ready_pkts() > 0 && !g)
      nstall++;
    if (pop)
      void'(q.pop_front());
    if (iss) begin
      margs = oplen(h) - 1;
      nhdr++;
    end else if (pop) begin
      margs--;
    end
    if (acc) begin
      if (wleft == 0) begin
        if (d[15:0] > 16'd3)
          mbad = 1;
        wleft = oplen(d) - 1;
      end else begin
        wleft--;
      end
      q.push_back(d);
    end
    @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk);
    model_clear();
    @(negedge clk);
    rst       = 1'b0;
    gpu_ready = 1'b0;
    #1;
    chk("rst_dv", {31'd0, dv}, 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_wr_ready", {31'd0, wr_ready}, 32'd1);
    chk("rst_bad_op", {31'd0, bad_op}, 32'd0);
  endtask

  task automatic idle(input int n, input bit g);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 32'd0, g);
  endtask

  task automatic gen_packet();
    int          r;
    logic [31:0] h;
    r = $urandom_range(0, 9);
    h = $urandom;
    if (r < 9)
      h[15:0] = 16'(r % 4);
    else
      h[15:0] = 16'($urandom_range(4, 65535));
    gen.push_back(h);
    for (int i = 1; i < oplen(h); i++)
      gen.push_back($urandom);
  endtask

  initial begin
    int h0;
    rst       = 1'b1;
    wr_valid  = 1'b0;
    wr_data   = 32'd0;
    gpu_ready = 1'b0;
    margs     = 0;
    wleft     = 0;
    mbad      = 0;
    nhdr      = 0;
    nstall    = 0;
    repeat (2) @(posedge clk);
    do_reset();

    // Rect forwarding
    cycle(1'b1, 32'h0001_0003, 1'b1);
    cycle(1'b1, 32'h0020_0010, 1'b1);
    cycle(1'b1, 32'h0008_0004, 1'b1);
    idle(4, 1'b1);

    // Hold until complete
    cycle(1'b1, 32'h0002_0001, 1'b1);
    for (int i = 0; i < 3; i++)
      cycle(1'b1, 32'h1000_0000 + 32'(i), 1'b1);
    idle(20, 1'b1);
    cycle(1'b1, 32'h1000_00FF, 1'b1);
    idle(6, 1'b1);

    // Back-pressure
    cycle(1'b1, 32'h0000_0000, 1'b1);
    cycle(1'b1, 32'h0000_0002, 1'b1);
    cycle(1'b1, 32'h0005_000A, 1'b0);
    idle(9, 1'b0);
    idle(4, 1'b1);

    // Full and wrap
    for (int i = 0; i < 20; i++)
      cycle(1'b1, 32'(i) << 20, 1'b0);
    #1;
    chk("full_level", 32'(level), 32'd16);
    chk("full_wr_ready", {31'd0, wr_ready}, 32'd0);
    h0 = nhdr;
    idle(24, 1'b1);
    chk("full_hdrs", 32'(nhdr - h0), 32'd16);

    // Unknown opcode
    cycle(1'b1, 32'h0000_0007, 1'b1);
    idle(3, 1'b1);
    chk("unk_bad_op", {31'd0, bad_op}, 32'd1);

    // Reset mid-stream during Rect args
    cycle(1'b1, 32'h0003_0003, 1'b1);
    cycle(1'b1, 32'h0000_1111, 1'b1);
    cycle(1'b1, 32'h0000_2222, 1'b1);
    cycle(1'b0, 32'd0, 1'b1);
    do_reset();
    cycle(1'b1, 32'h0000_0002, 1'b1);
    cycle(1'b1, 32'h0005_000A, 1'b1);
    idle(4, 1'b1);

    // Random traffic
    do_reset();
    nhdr   = 0;
    nstall = 0;
    for (int i = 0; i < 1500; i++) begin
      bit v;
      bit g;
      logic [31:0] d;
      v = ($urandom_range(0, 3) != 0);
      g = ($urandom_range(0, 2) != 0);
      d = 32'd0;
      if (v) begin
        if (gen.size() == 0)
          gen_packet();
        d = gen[0];
        if (q.size() < DEPTH)
          void'(gen.pop_front());
      end
      cycle(v, d, g);
    end
`ifdef GPU_CMDQ_STATS_EN
    #1;
    chk("cmd_count", cmd_count, 32'(nhdr));
`endif

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

// File: doc/gpu_cmd_queue.md
# gpu_cmd_queue

Packet-aware command buffer between the CPU's memory-mapped GPU port and the `dv`/`din`/`ready` input of the GPU. It accepts 32-bit command words from the CPU at up to one per cycle, buffers them, and releases a command to the GPU only when the whole packet (header plus arguments) is resident. The header goes out when the GPU is idle, and the arguments follow on back-to-back cycles, which is the only form the GPU argument-read state accepts.

## Interface
- `DEPTH`, 16: FIFO depth in 32-bit words. Power of two, ≥ 8.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `wr_valid`  in  1  CPU word strobe.
- `wr_data`  in  32  CPU command word.
- `wr_ready`  out  1  space available. Equals `!full`.
- `dv`  out  1  header strobe to the GPU.
- `dout`  out  32  word to the GPU.
- `gpu_ready`  in  1  GPU idle (the GPU's `ready`).
- `level`  out  $clog2(DEPTH)+1  words currently buffered.
- `bad_op`  out  1  sticky flag: an unknown opcode was written. Cleared by `rst` only.

## Operation
- **Header format:** opcode in bits [15:0], color in [17:16]. The block forwards every word unmodified.
- **Packet lengths (header + arguments):**
  - Swap (0): 1 word.
  - ChangeColorMap (1): 5 words.
  - Pixel (2): 2 words.
  - Rect (3): 3 words.
  - Any other opcode: 1 word, and it sets `bad_op`.
- **Write-side parser:** `wpos` counts words into the current packet. On each accepted write (`wr_valid && wr_ready`):
  - If `wpos == 0`, the word is a header. Latch its length into `wlen`.
  - When `wpos == wlen-1`, increment `pkts` (complete packets buffered) and clear `wpos`.
- **Read-side FSM:**
  - IDLE: if `pkts != 0 && gpu_ready`, assert `dv=1` with `dout` = the header, pop it, decrement `pkts`, and load `rem` = length-1. Go to ARGS if `rem != 0`, otherwise stay in IDLE.
  - ARGS: `dv=0`, `dout` = next word, pop, `rem--`. Return to IDLE when `rem` reaches 0. `gpu_ready` is ignored in ARGS, and the arguments are guaranteed present.
- **`dout` is driven from the FIFO head combinationally;** the pop is registered. When not popping, `dout` holds the head word, or 0 if the FIFO is empty.
- **Simultaneous `pkts` increment and decrement** leave it unchanged. Simultaneous push and pop leave `level` unchanged.
- **Full:** `wr_ready=0`. A write while full is dropped, and the parser does not advance.
- **Empty:** no pop occurs. This cannot happen in ARGS.
- **Reset:** mid-packet on either side, all state clears. `dv=0`, `level=0`, `wr_ready=1`, `bad_op=0`, FSM=IDLE, `wpos=0`, `pkts=0`. Partially written packets are discarded.
- **Pointer wrap:** pointers are $clog2(DEPTH)+1 bits wide. Full is defined as MSBs differ with the lower bits equal. They wrap modulo 2·DEPTH.

## Timing
- **Write to visibility:** a packet's last word written in cycle N makes `pkts` nonzero in N+1. The earliest `dv` is N+1.
- **Header cycle H** (`dv=1`, `gpu_ready=1`): the argument words appear on `dout` in cycles H+1 … H+len-1, with `dv=0`.
- **Next header:** the earliest next `dv` is H+len, and only if `gpu_ready=1` in that cycle. The GPU drops `ready` after taking a header, which stalls a following Swap until the swap completes.
- **Throughput:** one word per cycle on each side.

## Configuration
- `GPU_CMDQ_STATS_EN`:
  - **Defined:** adds a 32-bit `cmd_count` output, incremented on every header issued (saturates at 2^32-1), and a 32-bit `stall_count`, incremented each cycle with `pkts != 0 && !gpu_ready`. Both reset to 0.
  - **Undefined:** neither port nor counter exists.

## Structure
- **Shared package `gpu_pkg`:** opcode constants (`GPU_OP_SWAP`, `GPU_OP_CMAP`, `GPU_OP_PIXEL`, `GPU_OP_RECT`) and the function `gpu_op_len(op)` returning 1/5/2/3 (1 for unknown). The GPU core shares these constants.
- **Sub-module `cmd_fifo`:** synchronous single-clock FIFO with push/pop/full/empty/level and show-ahead head data. The parser, packet counter and FSM live in `gpu_cmd_queue`.

## Test plan
- **Rect forwarding:** write 0x0001_0003, 0x0020_0010, 0x0008_0004 with `gpu_ready=1`.
  - `dv=1` with `dout`=0x0001_0003 one cycle after the last write.
  - Next two cycles: `dv=0`, `dout`=0x0020_0010 then 0x0008_0004.
- **Hold until complete:** write only 4 of 5 ChangeColorMap words. No `dv` for 20 cycles. Write the 5th: `dv` the next cycle, then 4 argument cycles.
- **Back-pressure:** queue Swap then Pixel (0x2, 0x0005_000A) with `gpu_ready` low for 10 cycles after the Swap header. The Pixel header is issued in the first cycle `gpu_ready` returns high.
- **Full and wrap:** with DEPTH=16, write 20 Swap words with `gpu_ready=0`. `wr_ready=0` at `level`=16, and writes 17–20 are dropped. Release: exactly 16 headers, in order.
- **Unknown opcode:** write 0x0000_0007. `bad_op=1` and a 1-word packet is forwarded.
- **Reset mid-stream:** assert `rst` during ARGS of a Rect. The next cycle shows `dv=0`, `level=0`, `wr_ready=1`. A subsequent Pixel packet forwards correctly.
